pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed per-stage flip-flop banks between fetch/decode/execute/memory/writeback.
- Carries a payload split into three parts:
  - a control bundle, which is cleared on bubbles;
  - a datapath bundle, which is held or passed through;
  - the instruction word, which becomes NOP on bubbles.
- Supports stall (hold), flush (squash), per-entry valid and DEPTH back-to-back register stages.
- One instance is placed between each pair of pipeline stages.

Parameters:
- CTRL_W, 8: width of control bundle (regWrt, wbDataSel, memWrt, branchInst, ...). Forced to zero on any bubble.
- DATA_W, 64: width of datapath bundle (aluFinal, memOut, addPC, imm, ...). Not cleared on bubbles.
- INSTR_W, 16: instruction word width.
- NOP_INSTR, 16'h0800: instruction value loaded on reset, flush or bubble.
- DEPTH, 1: number of cascaded register stages (1..4). All stages share stall/flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold all stages at current contents.
- flush  in  1  squash all stages to bubbles.
- validIn  in  1  upstream entry is a real instruction.
- ctrlIn  in  CTRL_W  upstream control bundle.
- dataIn  in  DATA_W  upstream datapath bundle.
- instrIn  in  INSTR_W  upstream instruction word.
- validOut  out  1  last stage holds a real instruction.
- ctrlOut  out  CTRL_W  last stage control bundle.
- dataOut  out  DATA_W  last stage datapath bundle.
- instrOut  out  INSTR_W  last stage instruction word.
- busy  out  1  OR of valid bits of all DEPTH stages.

Behaviour:
- Reset: one clock, synchronous, active-high. Port names are clk and rst. At a rising edge with rst=1, every stage loads:
  - valid=0, ctrl=0, data=0, instr=NOP_INSTR.
  - Therefore validOut=0, ctrlOut=0, dataOut=0, instrOut=NOP_INSTR, busy=0 in the cycle after reset.
  - rst overrides stall and flush.
  - rst asserted mid-stream discards all entries with no partial drain.
- Priority per edge: rst > flush > stall > normal advance.
- Flush: all stages load the bubble value (valid=0, ctrl=0, instr=NOP_INSTR). Data contents are don't-care; the implementation holds them. Flush while stalled still squashes.
- Stall (flush=0): every stage holds; inputs are ignored. Outputs are constant for the whole stall duration.
- Normal advance (stall=0, flush=0):
  - stage0 loads valid=validIn.
  - ctrl=validIn ? ctrlIn : 0.
  - instr=validIn ? instrIn : NOP_INSTR.
  - data=dataIn, captured regardless of validIn.
  - Stage k loads stage k-1 for k=1..DEPTH-1.
- Latency: an input accepted at edge N appears on the outputs after edge N+DEPTH-1, i.e. DEPTH cycles of register delay. Latency grows by one per stalled cycle.
- Invariant: validOut=0 implies ctrlOut=0 and instrOut=NOP_INSTR, so downstream write enables never fire on bubbles.
- Outputs are driven directly from the last stage registers; there is no combinational path from inputs to outputs.
- busy is a registered-valid OR; it is combinational from stage valids only.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, adds two output ports:
  - stallCnt [15:0]: counts edges where stall=1, flush=0, rst=0 and busy=1.
  - flushCnt [15:0]: counts edges where flush=1, rst=0 and busy=1, i.e. edges that squashed at least one real entry.
- Both counters saturate at 16'hFFFF (no wrap) and reset to 0 on rst.
- When not defined, the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with validIn=1, ctrlIn=8'hFF, instrIn=16'h1234 -> validOut=0, ctrlOut=0, dataOut=0, instrOut=16'h0800, busy=0.
- Pass-through (DEPTH=1): validIn=1, ctrlIn=8'hA5, dataIn=64'h0123_4567_89AB_CDEF, instrIn=16'hC0DE at edge N -> same values on the outputs after edge N. Then validIn=0 with ctrlIn=8'hFF -> ctrlOut=0, instrOut=16'h0800, dataOut follows dataIn.
- Stall: load instr 16'h1111, then stall=1 for 3 cycles while instrIn=16'h2222 -> instrOut stays 16'h1111 for all 3 cycles. Release -> 16'h2222 appears one edge later.
- Flush beats stall: with valid entry 16'h3333 and stall=1, flush=1 -> next cycle validOut=0, ctrlOut=0, instrOut=16'h0800, busy=0.
- DEPTH=3: inject 16'hA001, 16'hA002, 16'hA003 on consecutive edges -> 16'hA001 appears on outputs 2 edges after injection, in order. A stall of 1 cycle mid-stream delays every entry by exactly 1 cycle, with none lost or duplicated.
- PIPE_STAGE_STATS_EN:
  - 5 stalled cycles with busy=1 plus 2 with busy=0 -> stallCnt=5.
  - 1 flush with busy=1 -> flushCnt=1.
  - Forced 70000 stalls -> stallCnt=16'hFFFF.
  - rst -> both counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH cascaded stages with shared stall/flush and bubble insertion.
// Define PIPE_STAGE_STATS_EN to add saturating stall/flush event counters (stallCnt, flushCnt).

module pipe_stage_reg #(
  parameter int unsigned          CTRL_W    = 8,
  parameter int unsigned          DATA_W    = 64,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(16'h0800),
  parameter int unsigned          DEPTH     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               validIn,
  input  logic [CTRL_W-1:0]  ctrlIn,
  input  logic [DATA_W-1:0]  dataIn,
  input  logic [INSTR_W-1:0] instrIn,
  output logic               validOut,
  output logic [CTRL_W-1:0]  ctrlOut,
  output logic [DATA_W-1:0]  dataOut,
  output logic [INSTR_W-1:0] instrOut,
  output logic               busy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]        stallCnt,
  output logic [15:0]        flushCnt
`endif
);

  logic               valid_q [DEPTH];
  logic [CTRL_W-1:0]  ctrl_q  [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];

  logic               valid_d [DEPTH];
  logic [CTRL_W-1:0]  ctrl_d  [DEPTH];
  logic [DATA_W-1:0]  data_d  [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];

  // Next-state: flush squashes (data held), stall holds, otherwise shift one stage.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      data_d[k]  = data_q[k];
      instr_d[k] = instr_q[k];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
        instr_d[k] = NOP_INSTR;
      end
    end else if (!stall) begin
      valid_d[0] = validIn;
      ctrl_d[0]  = validIn ? ctrlIn : '0;
      data_d[0]  = dataIn;
      instr_d[0] = validIn ? instrIn : NOP_INSTR;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
        instr_d[k] = instr_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
        instr_q[k] <= NOP_INSTR;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        data_q[k]  <= data_d[k];
        instr_q[k] <= instr_d[k];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      busy = busy | valid_q[k];
    end
  end

  assign validOut = valid_q[DEPTH-1];
  assign ctrlOut  = ctrl_q[DEPTH-1];
  assign dataOut  = data_q[DEPTH-1];
  assign instrOut = instr_q[DEPTH-1];

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Only count events that affected at least one real entry; saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !flush && busy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush && busy && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: DEPTH=1 and DEPTH=3 instances share all inputs.
// Counter checks run only when PIPE_STAGE_STATS_EN is defined.

module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, validIn;
  logic [7:0]  ctrlIn;
  logic [63:0] dataIn;
  logic [15:0] instrIn;

  logic        v1, b1, v3, b3;
  logic [7:0]  c1, c3;
  logic [63:0] d1, d3;
  logic [15:0] i1, i3;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .validIn(validIn), .ctrlIn(ctrlIn), .dataIn(dataIn), .instrIn(instrIn),
    .validOut(v1), .ctrlOut(c1), .dataOut(d1), .instrOut(i1), .busy(b1)
`ifdef PIPE_STAGE_STATS_EN
    , .stallCnt(sc1), .flushCnt(fc1)
`endif
  );

  pipe_stage_reg #(.DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .validIn(validIn), .ctrlIn(ctrlIn), .dataIn(dataIn), .instrIn(instrIn),
    .validOut(v3), .ctrlOut(c3), .dataOut(d3), .instrOut(i3), .busy(b3)
`ifdef PIPE_STAGE_STATS_EN
    , .stallCnt(sc3), .flushCnt(fc3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with live-looking inputs; none of them may leak through.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    validIn = 1'b1; ctrlIn = 8'hFF; dataIn = 64'hFFFF_0000_FFFF_0000; instrIn = 16'h1234;
    step(); step();
    check("rst_valid1", v1, 0);
    check("rst_ctrl1",  c1, 0);
    check("rst_data1",  d1, 0);
    check("rst_instr1", i1, 16'h0800);
    check("rst_busy1",  b1, 0);
    check("rst_valid3", v3, 0);
    check("rst_instr3", i3, 16'h0800);
    check("rst_busy3",  b3, 0);
`ifdef PIPE_STAGE_STATS_EN
    check("rst_scnt", sc1, 0);
    check("rst_fcnt", fc1, 0);
`endif

    // DEPTH=1 pass-through
    rst = 1'b0;
    validIn = 1'b1; ctrlIn = 8'hA5; dataIn = 64'h0123_4567_89AB_CDEF; instrIn = 16'hC0DE;
    step();
    check("pt_valid", v1, 1);
    check("pt_ctrl",  c1, 8'hA5);
    check("pt_data",  d1, 64'h0123_4567_89AB_CDEF);
    check("pt_instr", i1, 16'hC0DE);
    check("pt_busy",  b1, 1);

    // Bubble input: ctrl cleared, NOP instr, data still follows
    validIn = 1'b0; ctrlIn = 8'hFF; dataIn = 64'hDEAD_BEEF_0000_0001; instrIn = 16'h5555;
    step();
    check("bub_valid", v1, 0);
    check("bub_ctrl",  c1, 0);
    check("bub_instr", i1, 16'h0800);
    check("bub_data",  d1, 64'hDEAD_BEEF_0000_0001);
    check("bub_busy",  b1, 0);

    // Stall holds for 3 cycles, then the waiting input advances
    validIn = 1'b1; ctrlIn = 8'h11; dataIn = 64'h1111; instrIn = 16'h1111;
    step();
    check("st_load", i1, 16'h1111);
    stall = 1'b1; ctrlIn = 8'h22; dataIn = 64'h2222; instrIn = 16'h2222;
    for (int n = 0; n < 3; n++) begin
      step();
      check("st_hold_instr", i1, 16'h1111);
      check("st_hold_ctrl",  c1, 8'h11);
      check("st_hold_data",  d1, 64'h1111);
    end
    stall = 1'b0;
    step();
    check("st_release_instr", i1, 16'h2222);
    check("st_release_ctrl",  c1, 8'h22);

    // Flush beats stall
    instrIn = 16'h3333; ctrlIn = 8'h33;
    step();
    check("fl_load", i1, 16'h3333);
    stall = 1'b1; flush = 1'b1;
    step();
    check("fl_valid1", v1, 0);
    check("fl_ctrl1",  c1, 0);
    check("fl_instr1", i1, 16'h0800);
    check("fl_busy1",  b1, 0);
    check("fl_busy3",  b3, 0);
    stall = 1'b0; flush = 1'b0;

    // DEPTH=3 ordering and stall delay
    rst = 1'b1; validIn = 1'b0;
    step();
    rst = 1'b0;
    validIn = 1'b1; ctrlIn = 8'h01; dataIn = 64'h1; instrIn = 16'hA001;
    step();
    check("d3_e1_valid", v3, 0);
    check("d3_e1_busy",  b3, 1);
    ctrlIn = 8'h02; dataIn = 64'h2; instrIn = 16'hA002;
    step();
    check("d3_e2_instr", i3, 16'h0800);
    ctrlIn = 8'h03; dataIn = 64'h3; instrIn = 16'hA003;
    step();
    check("d3_e3_instr", i3, 16'hA001);
    check("d3_e3_valid", v3, 1);
    check("d3_e3_ctrl",  c3, 8'h01);
    stall = 1'b1; validIn = 1'b0; ctrlIn = 8'hEE; instrIn = 16'hBEEF;
    step();
    check("d3_stall_instr", i3, 16'hA001);
    stall = 1'b0;
    step();
    check("d3_e5_instr", i3, 16'hA002);
    check("d3_e5_data",  d3, 64'h2);
    step();
    check("d3_e6_instr", i3, 16'hA003);
    check("d3_e6_ctrl",  c3, 8'h03);
    step();
    check("d3_e7_valid", v3, 0);
    check("d3_e7_instr", i3, 16'h0800);
    check("d3_e7_ctrl",  c3, 0);
    check("d3_e7_busy",  b3, 0);

`ifdef PIPE_STAGE_STATS_EN
    // 5 busy stalls, 1 busy flush, 2 idle stalls
    rst = 1'b1;
    step();
    rst = 1'b0; validIn = 1'b1; instrIn = 16'h4444;
    step();
    stall = 1'b1;
    for (int n = 0; n < 5; n++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int n = 0; n < 2; n++) step();
    check("cnt_stall5", sc1, 16'd5);
    check("cnt_flush1", fc1, 16'd1);
    stall = 1'b0;

    // Saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    stall = 1'b1;
    for (int n = 0; n < 70000; n++) step();
    check("cnt_sat", sc1, 16'hFFFF);
    stall = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt_rst_stall", sc1, 0);
    check("cnt_rst_flush", fc1, 0);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
